// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select or round-robin arbitration.
// Optional accepted-output counter port out_count is enabled by defining STREAM_MUX_CNT_EN.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [15:0]        out_count
`endif
);

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] last;
    logic             rr_found;
    logic [WIDTH-1:0] data_mux;
    logic [SEL_W-1:0] chan_mux;
    logic             can_load;
    logic             take;

    logic [WIDTH-1:0] data_p0;
    logic [SEL_W-1:0] chan_p0;
    logic             vld_p0;

    // Round-robin search visits last+1 .. last (mod N); fixed mode ignores out-of-range sel.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                grant[i] = in_valid[i] && (sel == SEL_W'(i));
            end
        end else begin
            for (int off = 1; off <= N; off++) begin
                for (int i = 0; i < N; i++) begin
                    if (!rr_found && in_valid[i] && (((int'(last) + off) % N) == i)) begin
                        grant[i] = 1'b1;
                        rr_found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        data_mux = '0;
        chan_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_mux = in_data[i*WIDTH +: WIDTH];
                chan_mux = SEL_W'(i);
            end
        end
    end

    assign can_load = !vld_p0 || out_ready;
    assign in_ready = rst ? '0 : (grant & {N{can_load}});
    assign take     = |(in_valid & in_ready);

    // Stage p0: single-entry output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            last    <= SEL_W'(N - 1);
        end else if (take) begin
            vld_p0  <= 1'b1;
            data_p0 <= data_mux;
            chan_p0 <= chan_mux;
            if (mode) begin
                last <= chan_mux;
            end
        end else if (vld_p0 && out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_data  = data_p0;
    assign out_chan  = chan_p0;
    assign out_valid = vld_p0;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (vld_p0 && out_ready) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign out_count = cnt;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed phases push expected words, a monitor pops them.
// A second N=5 instance exercises select values that name no channel.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [39:0] d5;
    logic [4:0]  v5;
    logic [4:0]  r5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  od5;
    logic [2:0]  oc5;
    logic        ov5;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] out_count;
    logic [15:0] cnt5;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_chan_q[$];
    int exp_data_q[$];
    logic mon_en;

    stream_mux_rr #(.WIDTH(8), .N(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_MUX_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    stream_mux_rr #(.WIDTH(8), .N(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d5),
        .in_valid  (v5),
        .in_ready  (r5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (od5),
        .out_chan  (oc5),
        .out_valid (ov5),
        .out_ready (1'b1)
`ifdef STREAM_MUX_CNT_EN
        ,
        .out_count (cnt5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int ch);
        exp_chan_q.push_back(ch);
        exp_data_q.push_back(32'h10 + ch);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_left"}, exp_chan_q.size(), 0);
        check({name, "_drained"}, 32'(out_valid), 0);
    endtask

    always @(negedge clk) begin
        int ec;
        int ed;
        if (mon_en && !rst && out_valid && out_ready) begin
            if (exp_chan_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got chan %0d data 0x%0h, required no word", out_chan, out_data);
            end else begin
                ec = exp_chan_q.pop_front();
                ed = exp_data_q.pop_front();
                check("mon_out_chan", 32'(out_chan), ec);
                check("mon_out_data", 32'(out_data), ed);
            end
        end
    end

    initial begin
        int rr_seq[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        int skip_seq[6] = '{1, 3, 1, 3, 1, 3};

        rst       = 1'b1;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid  = 4'hF;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        d5        = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        v5        = 5'h1F;
        mode5     = 1'b0;
        sel5      = 3'd5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_chan", 32'(out_chan), 0);
        check("rst_in_ready5", 32'(r5), 0);

        // Round-robin over all four channels, starting at channel 0
        for (int i = 0; i < 8; i++) push(rr_seq[i]);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 in_valid = 4'h0;
        drain("rr_all");

        // Only channels 1 and 3 valid
        for (int i = 0; i < 6; i++) push(skip_seq[i]);
        in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("skip_in_ready_0_2", 32'(in_ready & 4'b0101), 0);
            @(posedge clk);
        end
        #1 in_valid = 4'h0;
        drain("rr_skip");

        // Fixed select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++) push(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fixed_in_ready", 32'(in_ready), 32'h4);
            @(posedge clk);
        end
        #1 in_valid = 4'h0;
        drain("fixed");

        // Fixed mode left the pointer at 3, so round-robin resumes at channel 0
        mode     = 1'b1;
        in_valid = 4'hF;
        push(0);
        push(1);
        repeat (2) @(posedge clk);
        #1 in_valid = 4'h0;
        drain("rr_resume");

        // Backpressure with the register full of channel 2
        push(2);
        push(3);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_chan", 32'(out_chan), 2);
            check("bp_out_data", 32'(out_data), 32'h12);
            check("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'h8);
        @(posedge clk);
        #1 in_valid = 4'h0;
        drain("backpressure");

        // Out-of-range select on the N=5 instance
        sel5 = 3'd1;
        @(posedge clk);
        #1 sel5 = 3'd5;
        @(negedge clk);
        check("sel5_loaded_valid", 32'(ov5), 1);
        check("sel5_loaded_chan", 32'(oc5), 1);
        check("sel5_loaded_data", 32'(od5), 32'h21);
        check("sel5_in_ready", 32'(r5), 0);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sel5_drained", 32'(ov5), 0);
            check("sel5_no_grant", 32'(r5), 0);
            @(posedge clk);
            #1 sel5 = 3'd7;
        end

        // Reset while streaming discards the held word
        mon_en   = 1'b0;
        in_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_data", 32'(out_data), 0);
`ifdef STREAM_MUX_CNT_EN
        check("midrst_count", 32'(out_count), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef STREAM_MUX_CNT_EN
        repeat (70000) @(posedge clk);
        #1 in_valid = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("count_70000", 32'(out_count), 4464);
        in_valid = 4'hF;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("count_rst", 32'(out_count), 0);
        check("count_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 4'h0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
